mem_responder_mc: RTL and testbench

//  Multi-cycle word memory that answers load/store requests from the CPU datapath.
//  The CPU issues enable/wr/addr/data; this block accepts one request, holds it for

---
 rtl/mem_responder_mc_pkg.sv | 19 +
 rtl/mem_responder_mc_if.sv | 30 +++
 rtl/mem_responder_mc_mem_array.sv | 28 ++
 rtl/mem_responder_mc.sv | 104 ++++++++++
 tb/tb_mem_responder_mc.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_mc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_responder_mc_pkg                                                 |
// | State encoding and counter width for the multi-cycle memory          |
// | responder.                                                           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mem_responder_mc_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_responder_mc_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_responder_mc_if                                                  |
// | Request/response bus between the CPU datapath and the responder.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface mem_responder_mc_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req_en;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              busy;
    logic              rsp_valid;
    logic              rsp_wr;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_en, req_wr, req_addr, req_wdata,
        input  busy, rsp_valid, rsp_wr, rsp_rdata
    );

    modport slave (
        input  req_en, req_wr, req_addr, req_wdata,
        output busy, rsp_valid, rsp_wr, rsp_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_responder_mc_mem_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_array                                                            |
// | Synchronous single-port word array, registered read, no reset.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_array #(
    parameter int DEPTH_W = 10,
    parameter int DATA_W  = 16
) (
    input  wire logic               clk,
    input  wire logic               we,
    input  wire logic [DEPTH_W-1:0] idx,
    input  wire logic [DATA_W-1:0]  wdata,
    output logic      [DATA_W-1:0]  rdata
);

    logic [DATA_W-1:0] mem_q [2**DEPTH_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= wdata;
        end
        rdata <= mem_q[idx];
    end

endmodule
`default_nettype wire

// File: rtl/mem_responder_mc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_responder_mc                                                     |
// | Accepts one load/store, holds it LATENCY cycles, then responds.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_responder_mc
    import mem_responder_mc_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int DEPTH_W = 10,
    parameter int LATENCY = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    mem_responder_mc_if.slave bus
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               wr_q;
    logic [DEPTH_W-1:0] idx_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  rdata_q;
    logic [DATA_W-1:0]  arr_rdata;
    logic               arr_we;
    logic               accept;
    logic               access;
    logic               w_unused_addr;

    assign accept        = bus.req_en && (state_q != ST_WAIT);
    assign access        = (state_q == ST_WAIT) && (count_q == '0);
    assign w_unused_addr = ^{bus.req_addr[ADDR_W-1:DEPTH_W+1], bus.req_addr[0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.req_en) state_d = ST_WAIT;
            ST_WAIT: if (count_q == '0) state_d = ST_RESP;
            ST_RESP: state_d = bus.req_en ? ST_WAIT : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Load data is shown straight from the array during RESP, then held in rdata_q.
    always_comb begin
        bus.busy      = (state_q == ST_WAIT);
        bus.rsp_valid = (state_q == ST_RESP);
        bus.rsp_wr    = (state_q == ST_RESP) && wr_q;
        bus.rsp_rdata = ((state_q == ST_RESP) && !wr_q) ? arr_rdata : rdata_q;
        arr_we        = access && wr_q;
    end

    always_comb begin
        count_d = count_q;
        if (accept) begin
            count_d = CNT_W'(LATENCY - 1);
        end else if ((state_q == ST_WAIT) && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            count_q <= count_d;
            if (accept) begin
                wr_q    <= bus.req_wr;
                idx_q   <= bus.req_addr[DEPTH_W:1];
                wdata_q <= bus.req_wdata;
            end
            if ((state_q == ST_RESP) && !wr_q) begin
                rdata_q <= arr_rdata;
            end
        end
    end

    mem_array #(
        .DEPTH_W (DEPTH_W),
        .DATA_W  (DATA_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .idx   (idx_q),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_mem_responder_mc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_responder_mc                                                  |
// | Directed + random load/store traffic on LATENCY=4 and LATENCY=1.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mem_responder_mc;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_responder_mc_if #(.ADDR_W(16), .DATA_W(16)) if4 ();
    mem_responder_mc_if #(.ADDR_W(16), .DATA_W(16)) if1 ();

    mem_responder_mc #(.ADDR_W(16), .DATA_W(16), .DEPTH_W(10), .LATENCY(4)) dut4 (
        .clk (clk), .rst (rst), .bus (if4.slave)
    );
    mem_responder_mc #(.ADDR_W(16), .DATA_W(16), .DEPTH_W(10), .LATENCY(1)) dut1 (
        .clk (clk), .rst (rst), .bus (if1.slave)
    );

    int total = 0;
    int bad   = 0;
    logic sel = 1'b0;

    logic [15:0] m4 [int];
    logic [15:0] m1 [int];
    logic [15:0] last4 = 16'h0;
    logic [15:0] last1 = 16'h0;

    wire        o_busy  = sel ? if1.busy      : if4.busy;
    wire        o_valid = sel ? if1.rsp_valid : if4.rsp_valid;
    wire        o_wr    = sel ? if1.rsp_wr    : if4.rsp_wr;
    wire [15:0] o_rdata = sel ? if1.rsp_rdata : if4.rsp_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic en, input logic wr, input logic [15:0] a, input logic [15:0] d);
        if (sel) begin
            if1.req_en = en; if1.req_wr = wr; if1.req_addr = a; if1.req_wdata = d;
        end else begin
            if4.req_en = en; if4.req_wr = wr; if4.req_addr = a; if4.req_wdata = d;
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"},  32'(o_busy),  32'h0);
        chk({tag, "_valid"}, 32'(o_valid), 32'h0);
        chk({tag, "_wr"},    32'(o_wr),    32'h0);
        chk({tag, "_rdata"}, 32'(o_rdata), 32'h0);
    endtask

    // One transaction, called at a negedge with the DUT able to accept on the next edge.
    task automatic do_req(input logic wr, input logic [15:0] a, input logic [15:0] d,
                          input bit keep, input bit scramble, input string tag);
        int n, nbusy, idx, lat;
        bit seen, known;
        logic [15:0] exp;
        lat   = sel ? 1 : 4;
        idx   = int'(a[10:1]);
        n     = 0;
        nbusy = 0;
        seen  = 1'b0;
        set_req(1'b1, wr, a, d);
        @(posedge clk);
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (o_busy) nbusy++;
            if (o_valid) seen = 1'b1;
            if (scramble && n == 1) set_req(1'b1, ~wr, a ^ 16'h07F6, 16'($urandom));
        end
        chk({tag, "_seen"},  32'(seen),  32'h1);
        chk({tag, "_lat"},   32'(n),     32'(lat + 1));
        chk({tag, "_nbusy"}, 32'(nbusy), 32'(lat));
        chk({tag, "_rspwr"}, 32'(o_wr),  32'(wr));
        known = 1'b1;
        if (wr) begin
            exp = sel ? last1 : last4;
            if (sel) m1[idx] = d; else m4[idx] = d;
        end else if (sel ? m1.exists(idx) : m4.exists(idx)) begin
            exp = sel ? m1[idx] : m4[idx];
            if (sel) last1 = exp; else last4 = exp;
        end else begin
            known = 1'b0;
            exp   = 16'h0;
        end
        if (known) chk({tag, "_rdata"}, 32'(o_rdata), 32'(exp));
        if (!keep) begin
            set_req(1'b0, 1'b0, 16'h0, 16'h0);
            @(negedge clk);
            chk({tag, "_pulse"}, 32'(o_valid), 32'h0);
            chk({tag, "_idle"},  32'(o_busy),  32'h0);
        end
    endtask

    initial begin
        int v;
        int idx;
        logic [15:0] a;
        bit keep;
        set_req(1'b0, 1'b0, 16'h0, 16'h0);
        sel = 1'b1;
        set_req(1'b0, 1'b0, 16'h0, 16'h0);
        sel = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk_idle_outputs("reset4");
        sel = 1'b1; #1;
        chk_idle_outputs("reset1");
        sel = 1'b0;
        @(negedge clk);

        // Preload array[8], reset again (contents must survive), then load it
        do_req(1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0, "pre_beef");
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        last4 = 16'h0; last1 = 16'h0;
        do_req(1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, "load_beef");

        // Store then load in the RESP cycle (odd byte address, same word)
        do_req(1'b1, 16'h0020, 16'h1234, 1'b1, 1'b0, "raw_st");
        do_req(1'b0, 16'h0021, 16'h0, 1'b0, 1'b0, "raw_ld");

        // Request fields scrambled while busy
        do_req(1'b0, 16'h0010, 16'h0, 1'b0, 1'b1, "scr_ld");
        do_req(1'b1, 16'h0030, 16'h4321, 1'b0, 1'b1, "scr_st");
        do_req(1'b0, 16'h0030, 16'h0, 1'b0, 1'b0, "scr_chk");

        // Back-to-back loads with req_en held
        do_req(1'b0, 16'h0010, 16'h0, 1'b1, 1'b0, "b2b_0");
        do_req(1'b0, 16'h0020, 16'h0, 1'b1, 1'b0, "b2b_1");
        do_req(1'b0, 16'h0030, 16'h0, 1'b0, 1'b0, "b2b_2");

        // Aliasing: upper address bits ignored
        do_req(1'b0, 16'hF810, 16'h0, 1'b0, 1'b0, "alias");

        // Reset during WAIT of a store
        do_req(1'b1, 16'h0004, 16'h5555, 1'b0, 1'b0, "pre_5555");
        set_req(1'b1, 1'b1, 16'h0004, 16'hAAAA);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_idle_outputs("rst_mid");
        set_req(1'b0, 1'b0, 16'h0, 16'h0);
        last4 = 16'h0; last1 = 16'h0;
        @(negedge clk);
        rst = 1'b0;
        v = 0;
        repeat (6) begin
            @(negedge clk);
            if (o_valid) v++;
        end
        chk("rst_novalid", 32'(v), 32'h0);
        do_req(1'b0, 16'h0004, 16'h0, 1'b0, 1'b0, "rst_old");

        // Random traffic, LATENCY=4
        for (int i = 0; i < 16; i++) do_req(1'b1, 16'(i << 1), 16'($urandom), 1'b0, 1'b0, "fill4");
        for (int i = 0; i < 40; i++) begin
            idx  = $urandom_range(0, 15);
            a    = 16'(($urandom_range(0, 31) << 11) | (idx << 1) | $urandom_range(0, 1));
            keep = (i != 39) && ($urandom_range(0, 1) == 1);
            do_req(1'($urandom_range(0, 1)), a, 16'($urandom), keep, 1'($urandom_range(0, 1)), "rnd4");
        end

        // LATENCY=1: load then store, then random traffic
        sel = 1'b1;
        @(negedge clk);
        do_req(1'b1, 16'h0010, 16'h0F0F, 1'b0, 1'b0, "l1_pre");
        do_req(1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, "l1_ld");
        do_req(1'b1, 16'h0012, 16'h7E57, 1'b0, 1'b0, "l1_st");
        do_req(1'b0, 16'h0013, 16'h0, 1'b0, 1'b0, "l1_chk");
        for (int i = 0; i < 16; i++) do_req(1'b1, 16'(i << 1), 16'($urandom), 1'b0, 1'b0, "fill1");
        for (int i = 0; i < 30; i++) begin
            idx  = $urandom_range(0, 15);
            a    = 16'(($urandom_range(0, 31) << 11) | (idx << 1) | $urandom_range(0, 1));
            keep = (i != 29) && ($urandom_range(0, 1) == 1);
            do_req(1'($urandom_range(0, 1)), a, 16'($urandom), keep, 1'($urandom_range(0, 1)), "rnd1");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
